// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//   Registered immediate extension unit for the multicycle MIPS datapath.
//   It supports zero extension, sign extension, LUI placement, branch offset
//   and jump offset. The extension is computed when an immediate is accepted.
//   The {err, data} result is then held in a two-entry valid/ready buffer, so
//   the producer (ID) and the consumer (EX) can stall independently.
//
// Parameters
//   IN_W      immediate input width
//   OUT_W     extended output width, must be >= 2*IN_W
//   SHIFT_BR  left shift applied in the BRANCH and JUMP modes
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous reset, active-high
//   flush            synchronous flush, empties the buffer
//   in_valid         an immediate is presented
//   in_ready         unit can accept an immediate (registered)
//   immediate_value  raw immediate
//   extend_mode      0 ZERO, 1 SIGN, 2 LUI, 3 BRANCH, 4 JUMP, 5-7 illegal
//   out_valid        head entry is valid (registered)
//   out_ready        consumer accepts the head entry
//   extended_imm     extended result of the head entry (registered)
//   out_err          head entry carried an illegal mode (registered)
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int SHIFT_BR = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  immediate_value,
    input  logic [2:0]       extend_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] extended_imm,
    output logic             out_err
);

    generate
        if (OUT_W < 2 * IN_W) begin : g_width_check
            $error("imm_extend_pipe: OUT_W must be >= 2*IN_W");
        end
    endgenerate

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [2:0] MODE_ZERO   = 3'd0;
    localparam logic [2:0] MODE_SIGN   = 3'd1;
    localparam logic [2:0] MODE_LUI    = 3'd2;
    localparam logic [2:0] MODE_BRANCH = 3'd3;
    localparam logic [2:0] MODE_JUMP   = 3'd4;

    // Returns {err, data}. Illegal modes give zero data with err set.
    function automatic logic [OUT_W:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [2:0]      mode);
        logic [OUT_W-1:0] zext;
        logic [OUT_W-1:0] sext;
        zext = {{(OUT_W-IN_W){1'b0}}, imm};
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (mode)
            MODE_ZERO:   extend = {1'b0, zext};
            MODE_SIGN:   extend = {1'b0, sext};
            MODE_LUI:    extend = {1'b0, zext << (OUT_W - IN_W)};
            MODE_BRANCH: extend = {1'b0, sext << SHIFT_BR};
            MODE_JUMP:   extend = {1'b0, zext << SHIFT_BR};
            default:     extend = {1'b1, {OUT_W{1'b0}}};
        endcase
    endfunction

    logic [1:0]     state_r;
    logic [1:0]     state_nx_s;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [OUT_W:0] head_r;
    logic [OUT_W:0] skid_r;
    logic [OUT_W:0] head_nx_s;
    logic [OUT_W:0] ext_s;
    logic           head_load_s;
    logic           skid_load_s;
    logic           accept_s;
    logic           pop_s;

    assign ext_s    = extend(immediate_value, extend_mode);
    // in_valid is ignored while in_ready is low; the producer holds its data.
    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_r & out_ready;

    // Buffer next-state and entry-load decisions. Flush overrides any handshake.
    always_comb begin
        state_nx_s  = state_r;
        head_nx_s   = ext_s;
        head_load_s = 1'b0;
        skid_load_s = 1'b0;
        if (flush) begin
            state_nx_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nx_s  = ST_ONE;
                        head_load_s = 1'b1;
                    end else begin
                        state_nx_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && !pop_s) begin
                        state_nx_s  = ST_TWO;
                        skid_load_s = 1'b1;
                    end else if (accept_s && pop_s) begin
                        // Pass-through: the new entry replaces the departing head.
                        state_nx_s  = ST_ONE;
                        head_load_s = 1'b1;
                    end else if (pop_s) begin
                        state_nx_s = ST_EMPTY;
                    end else begin
                        state_nx_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so no accept can occur.
                    if (pop_s) begin
                        state_nx_s  = ST_ONE;
                        head_nx_s   = skid_r;
                        head_load_s = 1'b1;
                    end else begin
                        state_nx_s = ST_TWO;
                    end
                end
                default: begin
                    state_nx_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State, handshake flags and buffer entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_r      <= {(OUT_W+1){1'b0}};
            skid_r      <= {(OUT_W+1){1'b0}};
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s != ST_TWO);
            out_valid_r <= (state_nx_s != ST_EMPTY);
            if (head_load_s) begin
                head_r <= head_nx_s;
            end
            if (skid_load_s) begin
                skid_r <= ext_s;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign extended_imm = head_r[OUT_W-1:0];
    assign out_err      = head_r[OUT_W];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_pipe
//   Directed bench for imm_extend_pipe with hand-computed expected values.
//   The bench changes inputs 1 time unit after a rising edge and samples
//   outputs at that same point.
// ---------------------------------------------------------------------------
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] immediate_value;
    logic [2:0]  extend_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] extended_imm;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHIFT_BR(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .immediate_value (immediate_value),
        .extend_mode     (extend_mode),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .extended_imm    (extended_imm),
        .out_err         (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] imm);
        in_valid        = v;
        extend_mode     = m;
        immediate_value = imm;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 3'd0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_data", extended_imm, 32'h0);
        check("rst_err", out_err, 1'b0);
        rst = 1'b0;

        // 1: SIGN 8001
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 16'h8001);
        tick();
        check("t1_valid", out_valid, 1'b1);
        check("t1_data", extended_imm, 32'hFFFF8001);
        check("t1_err", out_err, 1'b0);

        // 2: back-to-back modes on F234, one result per cycle
        drive(1'b1, 3'd0, 16'hF234); tick();
        check("t2_zero", extended_imm, 32'h0000F234);
        check("t2_zero_valid", out_valid, 1'b1);
        drive(1'b1, 3'd2, 16'hF234); tick();
        check("t2_lui", extended_imm, 32'hF2340000);
        drive(1'b1, 3'd3, 16'hF234); tick();
        check("t2_branch", extended_imm, 32'hFFFFC8D0);
        drive(1'b1, 3'd4, 16'hF234); tick();
        check("t2_jump", extended_imm, 32'h0003C8D0);
        check("t2_in_ready", in_ready, 1'b1);
        drive(1'b0, 3'd0, 16'h0000); tick();
        check("t2_drain", out_valid, 1'b0);

        // 3: fill with out_ready low, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0001); tick();
        check("t3_one_ready", in_ready, 1'b1);
        drive(1'b1, 3'd0, 16'h0002); tick();
        check("t3_full_ready", in_ready, 1'b0);
        check("t3_head_a", extended_imm, 32'h1);
        // in_valid while full must be ignored
        drive(1'b1, 3'd0, 16'h0003); tick();
        check("t3_hold_data", extended_imm, 32'h1);
        check("t3_hold_valid", out_valid, 1'b1);
        drive(1'b0, 3'd0, 16'h0000);
        out_ready = 1'b1; tick();
        check("t3_head_b", extended_imm, 32'h2);
        check("t3_b_valid", out_valid, 1'b1);
        check("t3_ready_back", in_ready, 1'b1);
        tick();
        check("t3_empty", out_valid, 1'b0);

        // 4: accept and pop together in ONE
        drive(1'b1, 3'd0, 16'h0010); tick();
        check("t4_c", extended_imm, 32'h10);
        drive(1'b1, 3'd0, 16'h0020); tick();
        check("t4_d", extended_imm, 32'h20);
        check("t4_valid", out_valid, 1'b1);
        check("t4_ready", in_ready, 1'b1);
        drive(1'b0, 3'd0, 16'h0000); tick();
        check("t4_empty", out_valid, 1'b0);

        // 5: illegal mode then legal
        drive(1'b1, 3'd6, 16'h1234); tick();
        check("t5_ill_data", extended_imm, 32'h0);
        check("t5_ill_err", out_err, 1'b1);
        drive(1'b1, 3'd1, 16'h0005); tick();
        check("t5_sign_data", extended_imm, 32'h5);
        check("t5_sign_err", out_err, 1'b0);
        drive(1'b0, 3'd0, 16'h0000); tick();

        // 6a: flush in TWO with in_valid high
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0007); tick();
        drive(1'b1, 3'd0, 16'h0008); tick();
        check("t6_full", in_ready, 1'b0);
        flush = 1'b1;
        drive(1'b1, 3'd0, 16'h0009); tick();
        check("t6_flush_valid", out_valid, 1'b0);
        check("t6_flush_ready", in_ready, 1'b1);
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0000);
        out_ready = 1'b1; tick();
        check("t6_nothing", out_valid, 1'b0);

        // 6b: flush in ONE beats a simultaneous accept
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h000A); tick();
        flush = 1'b1;
        drive(1'b1, 3'd0, 16'h000B); tick();
        check("t6b_flush_valid", out_valid, 1'b0);
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0000); tick();
        check("t6b_stays_empty", out_valid, 1'b0);

        // 6c: asynchronous reset mid-cycle while full
        drive(1'b1, 3'd1, 16'h8000); tick();
        drive(1'b1, 3'd0, 16'h0004); tick();
        check("t6c_full", in_ready, 1'b0);
        check("t6c_head", extended_imm, 32'hFFFF8000);
        drive(1'b0, 3'd0, 16'h0000);
        #2;
        rst = 1'b1;
        #1;
        check("t6c_rst_valid", out_valid, 1'b0);
        check("t6c_rst_ready", in_ready, 1'b1);
        check("t6c_rst_data", extended_imm, 32'h0);
        check("t6c_rst_err", out_err, 1'b0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t6c_lost", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
